// File: rtl/bus_write_arbiter_if.sv
// Shared internal-bus write port: requester bundle in, registered bus triplet plus per-requester ack/err out.
interface bus_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    lock;
  logic [4*N_REQ-1:0]  dest;
  logic [DW*N_REQ-1:0] wdata;
  logic                stall;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    err;
  logic                bus_we;
  logic [3:0]          bus_sel;
  logic [DW-1:0]       bus_data;

  modport master (
    output req, lock, dest, wdata, stall,
    input  ack, err, bus_we, bus_sel, bus_data
  );

  modport slave (
    input  req, lock, dest, wdata, stall,
    output ack, err, bus_we, bus_sel, bus_data
  );
endinterface

// File: rtl/bus_write_arbiter.sv
// Round-robin write arbiter for the shared internal bus, with locked multi-beat ownership.
// Latency 1 cycle (all outputs registered); stall suppresses the grant for that edge only.
module bus_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_write_arbiter_if.slave   bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int LW = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   own;
  logic [LW-1:0]   lcnt;
  logic [LW-1:0]   lcnt_nxt;

  logic [N_REQ-1:0] ack_q;
  logic [N_REQ-1:0] err_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [DW-1:0]    data_q;

  logic [3:0]       dest_a  [N_REQ];
  logic [DW-1:0]    wdata_a [N_REQ];

  logic [PW-1:0]    scan_idx;
  logic [PW-1:0]    win;
  logic             win_hit;
  logic [PW-1:0]    gnt;
  logic             gnt_hit;
  logic             gnt_valid;
  logic [N_REQ-1:0] gnt_oh;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dest_a[g]  = bus.dest[4*g+3:4*g];
    assign wdata_a[g] = bus.wdata[DW*g+DW-1:DW*g];
  end

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // 1001 and 1011..1111 have no register behind them in the demux.
  function automatic logic dest_ok(input logic [3:0] code);
    return (code <= 4'b1000) || (code == 4'b1010);
  endfunction

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    win      = ptr;
    win_hit  = 1'b0;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = PW'((32'(ptr) + k) % N_REQ);
      if (bus.req[scan_idx]) begin
        win     = scan_idx;
        win_hit = 1'b1;
      end
    end
  end

  assign gnt       = (state == OWN) ? own : win;
  assign gnt_hit   = (state == OWN) ? bus.req[own] : win_hit;
  assign gnt_valid = dest_ok(dest_a[gnt]);
  assign gnt_oh    = N_REQ'(1) << gnt;
  assign lcnt_nxt  = lcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      own    <= '0;
      lcnt   <= '0;
      ack_q  <= '0;
      err_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      we_q  <= 1'b0;
      if (!bus.stall) begin
        if (gnt_hit) begin
          if (gnt_valid) begin
            we_q   <= 1'b1;
            ack_q  <= gnt_oh;
            sel_q  <= dest_a[gnt];
            data_q <= wdata_a[gnt];
            if (state == IDLE) begin
              if (bus.lock[gnt] && MAX_LOCK > 1) begin
                state <= OWN;
                own   <= gnt;
                lcnt  <= LW'(1);
              end else begin
                ptr <= next_idx(gnt);
              end
            end else begin
              lcnt <= lcnt_nxt;
              if (!bus.lock[own] || 32'(lcnt_nxt) >= MAX_LOCK) begin
                state <= IDLE;
                ptr   <= next_idx(own);
                lcnt  <= '0;
              end
            end
          end else begin
            // Rejected beat: bus triplet holds, ownership ends.
            err_q <= gnt_oh;
            state <= IDLE;
            ptr   <= next_idx(gnt);
            lcnt  <= '0;
          end
        end else if (state == OWN) begin
          state <= IDLE;
          ptr   <= next_idx(own);
          lcnt  <= '0;
        end
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.bus_we   = we_q;
  assign bus.bus_sel  = sel_q;
  assign bus.bus_data = data_q;

endmodule
